// File: rtl/lcd_cmd_seq_if.sv
// Host-push and LCD-controller signals of the command sequencer.
//   slave  : sequencer side (lcd_cmd_seq)
//   master : host/controller side (bench or surrounding logic)
//   in_cmd/in_valid/in_ready : host push handshake
//   lcd_cmd/lcd_cmd_valid    : issue strobe to controller
//   lcd_busy/lcd_done        : controller status
//   seq_done/cmd_count/drop_err : sequencer status
interface lcd_cmd_seq_if;
  logic [2:0] in_cmd;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy;
  logic       lcd_done;
  logic       seq_done;
  logic [7:0] cmd_count;
  logic       drop_err;

  modport slave (
    input  in_cmd, in_valid, lcd_busy, lcd_done,
    output in_ready, lcd_cmd, lcd_cmd_valid, seq_done, cmd_count, drop_err
  );
  modport master (
    output in_cmd, in_valid, lcd_busy, lcd_done,
    input  in_ready, lcd_cmd, lcd_cmd_valid, seq_done, cmd_count, drop_err
  );
endinterface

// File: rtl/lcd_cmd_seq.sv
// Upstream command sequencer for the LCD controller.
// Buffers host opcodes in a DEPTH-entry FIFO and issues them one at a time
// as single-cycle lcd_cmd_valid pulses while lcd_busy is low. After a
// write-back (opcode 0) is issued it waits for lcd_done, then parks in
// FINISH (seq_done set, FIFO flushed, pushes refused) until reset.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : lcd_cmd_seq_if.slave (host push, controller issue, status)
module lcd_cmd_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  lcd_cmd_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, FINISH} state_t;

  state_t        state_q, state_d;
  logic [2:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic [2:0]    lcd_cmd_q;
  logic          lcd_cmd_valid_q;
  logic          seq_done_q;
  logic [7:0]    cmd_count_q;
  logic          drop_err_q;

  // Extra pointer MSB distinguishes full from empty. Full looks only at the
  // registered pointers, so a pop in the same cycle never frees a slot early.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign bus.in_ready = !full && (state_q != FINISH);
  assign push         = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.lcd_done)
          state_d = FINISH;
        else if (!empty && !bus.lcd_busy) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      // One dead cycle after every issue keeps strobes 2 cycles apart.
      ISSUE:     state_d = (lcd_cmd_q == 3'd0) ? WAIT_DONE : IDLE;
      WAIT_DONE: if (bus.lcd_done) state_d = FINISH;
      default:   state_d = FINISH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.in_cmd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (state_q == FINISH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_cmd_q       <= 3'd0;
      lcd_cmd_valid_q <= 1'b0;
      seq_done_q      <= 1'b0;
      cmd_count_q     <= 8'd0;
      drop_err_q      <= 1'b0;
    end else begin
      lcd_cmd_valid_q <= pop;
      if (pop) lcd_cmd_q <= mem[rd_ptr[AW-1:0]];
      if (pop && cmd_count_q != 8'hFF) cmd_count_q <= cmd_count_q + 8'd1;
      if (state_q == FINISH) seq_done_q <= 1'b1;
      if (bus.in_valid && !bus.in_ready) drop_err_q <= 1'b1;
    end
  end

  assign bus.lcd_cmd       = lcd_cmd_q;
  assign bus.lcd_cmd_valid = lcd_cmd_valid_q;
  assign bus.seq_done      = seq_done_q;
  assign bus.cmd_count     = cmd_count_q;
  assign bus.drop_err      = drop_err_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq: reset state, busy gating and spacing,
// FIFO full/drop, write-back/done termination, ready-respecting streaming,
// mid-operation reset and count saturation.
module tb_lcd_cmd_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   consec = 0;
  logic prev_vld = 1'b0;

  logic [2:0] got_q[$];
  int         got_cyc[$];
  logic [2:0] exp_q[$];

  lcd_cmd_seq_if bus();

  lcd_cmd_seq #(.DEPTH(8), .AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every issue strobe; flag any back-to-back strobes.
  always @(negedge clk) begin
    if (bus.lcd_cmd_valid) begin
      got_q.push_back(bus.lcd_cmd);
      got_cyc.push_back(cyc);
    end
    if (bus.lcd_cmd_valid && prev_vld) consec++;
    prev_vld = bus.lcd_cmd_valid;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_cmd   = 3'd0;
    bus.lcd_busy = 1'b0;
    bus.lcd_done = 1'b0;
    tick(2);
    reset = 1'b0;
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic push1(input logic [2:0] v);
    bus.in_cmd   = v;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Host that honours in_ready: only raises in_valid when ready is seen.
  task automatic push_hs(input int n);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 5000) begin
      bus.in_cmd   = 3'((i % 7) + 1);
      bus.in_valid = bus.in_ready;
      tick();
      if (bus.in_valid) begin
        exp_q.push_back(bus.in_cmd);
        i++;
      end
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("push_budget", i, n);
  endtask

  task automatic cmp_q(input string tag);
    int bad = 0;
    chk({tag, "_n"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk({tag, "_order"}, bad, 0);
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_lcd_cmd",   bus.lcd_cmd, 0);
    chk("rst_valid",     bus.lcd_cmd_valid, 0);
    chk("rst_seq_done",  bus.seq_done, 0);
    chk("rst_count",     bus.cmd_count, 0);
    chk("rst_drop",      bus.drop_err, 0);

    // 1: busy gating, 2-cycle spacing
    bus.lcd_busy = 1'b1;
    push1(3'd4);
    push1(3'd5);
    tick(68);
    chk("t1_none_busy", got_q.size(), 0);
    bus.lcd_busy = 1'b0;
    tick(10);
    exp_q = '{3'd4, 3'd5};
    cmp_q("t1");
    if (got_cyc.size() == 2) chk("t1_spacing", got_cyc[1] - got_cyc[0], 2);
    else                     chk("t1_spacing_n", got_cyc.size(), 2);
    chk("t1_count", bus.cmd_count, 2);
    chk("t1_lcd_cmd_hold", bus.lcd_cmd, 5);

    // 2: fill past full while busy
    do_reset();
    bus.lcd_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.in_cmd   = 3'((i % 7) + 1);
      bus.in_valid = 1'b1;
      if (i < 8) exp_q.push_back(bus.in_cmd);
      if (i == 8) chk("t2_ready_full", bus.in_ready, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t2_drop", bus.drop_err, 1);
    tick(5);
    chk("t2_none_busy", got_q.size(), 0);
    bus.lcd_busy = 1'b0;
    tick(30);
    cmp_q("t2");
    chk("t2_count", bus.cmd_count, 8);

    // 3: write-back then done, trailing command held
    do_reset();
    push1(3'd1);
    push1(3'd0);
    push1(3'd3);
    tick(10);
    exp_q = '{3'd1, 3'd0};
    cmp_q("t3_pre");
    chk("t3_ready_wait", bus.in_ready, 1);
    chk("t3_seq_pre", bus.seq_done, 0);
    bus.lcd_done = 1'b1;
    tick();
    bus.lcd_done = 1'b0;
    tick(5);
    chk("t3_seq_done", bus.seq_done, 1);
    chk("t3_ready_fin", bus.in_ready, 0);
    chk("t3_drop_pre", bus.drop_err, 0);
    push1(3'd2);
    tick(5);
    chk("t3_drop_fin", bus.drop_err, 1);
    cmp_q("t3_post");
    chk("t3_count", bus.cmd_count, 2);

    // 4: continuous push while draining
    do_reset();
    push_hs(20);
    tick(60);
    cmp_q("t4");
    chk("t4_drop", bus.drop_err, 0);
    chk("t4_count", bus.cmd_count, 20);

    // 5: reset in WAIT_DONE with 3 queued
    do_reset();
    push1(3'd5);
    push1(3'd0);
    tick(5);
    push1(3'd1);
    push1(3'd2);
    push1(3'd3);
    tick(3);
    exp_q = '{3'd5, 3'd0};
    cmp_q("t5_pre");
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_valid", bus.lcd_cmd_valid, 0);
    chk("t5_rst_count", bus.cmd_count, 0);
    chk("t5_rst_ready", bus.in_ready, 1);
    chk("t5_rst_seq",   bus.seq_done, 0);
    chk("t5_rst_drop",  bus.drop_err, 0);
    tick(2);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    tick(15);
    chk("t5_no_issue", got_q.size(), 0);
    chk("t5_count", bus.cmd_count, 0);

    // 6: count saturation
    do_reset();
    push_hs(300);
    tick(30);
    chk("t6_issued", got_q.size(), 300);
    chk("t6_count_sat", bus.cmd_count, 255);

    chk("spacing_all", consec, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
